// File: rtl/alu_mdu.sv
// alu_mdu: combinational ALU with a multi-cycle multiply/divide unit that
// writes a HI/LO register pair.
//
// Ports:
//   clk     - single clock, all state updates on the rising edge
//   reset_n - synchronous active-low reset
//   A, B    - WIDTH-bit operands
//   s       - immediate shift amount (SW bits)
//   op      - 5-bit operation select
//   start   - qualifies MULT/MULTU/DIV/DIVU/MTHI/MTLO (ops 16-19, 22, 23)
//   result  - combinational ALU result (also MFHI/MFLO read path)
//   busy    - registered, high while a multiply or divide is in flight
//   hi, lo  - registered HI/LO contents
module alu_mdu #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10,
  localparam int SW        = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [SW-1:0]    s,
  input  logic [4:0]       op,
  input  logic             start,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CMAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  // Full 2*WIDTH product; sign- or zero-extension selects MULT vs MULTU.
  function automatic logic [2*WIDTH-1:0] mul_fn(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic             sgn);
    logic signed [2*WIDTH-1:0] ea;
    logic signed [2*WIDTH-1:0] eb;
    logic signed [2*WIDTH-1:0] p;
    ea = sgn ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    eb = sgn ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    p  = ea * eb;
    return p;
  endfunction

  // Returns {remainder, quotient}. Divide-by-zero and the single signed
  // overflow case are pinned to fixed values instead of using the operators.
  function automatic logic [2*WIDTH-1:0] div_fn(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic             sgn);
    logic        [WIDTH-1:0] q;
    logic        [WIDTH-1:0] r;
    logic        [WIDTH-1:0] most_neg;
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    most_neg = {1'b1, {(WIDTH-1){1'b0}}};
    sa = a;
    sb = b;
    if (b == '0) begin
      q = '1;
      r = a;
    end else if (sgn && (a == most_neg) && (b == '1)) begin
      q = most_neg;
      r = '0;
    end else if (sgn) begin
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  logic [0:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  // Result is computed from the operands on the accepting edge and parked
  // here until the busy window expires, so later A/B changes cannot leak in.
  logic [2*WIDTH-1:0] pend_q, pend_d;

  assign busy = (state_q == RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

  always_comb begin
    result = '0;
    case (op)
      5'd0:        result = A + B;
      5'd1:        result = A - B;
      5'd2, 5'd7:  result = A | B;
      5'd3:        result = B << A[SW-1:0];
      5'd4:        result = $signed(B) >>> A[SW-1:0];
      5'd5:        result = B >> A[SW-1:0];
      5'd6:        result = A & B;
      5'd8:        result = A ^ B;
      5'd9:        result = ~(A | B);
      5'd10:       result = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      5'd11:       result = {{(WIDTH-1){1'b0}}, (A < B)};
      5'd12:       result = $signed(B) >>> s;
      5'd13:       result = B >> s;
      5'd14:       result = B << s;
      5'd15:       result = B << (WIDTH/2);
      5'd20:       result = hi_q;
      5'd21:       result = lo_q;
      default:     result = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    pend_d  = pend_q;
    if (state_q == IDLE) begin
      if (start) begin
        case (op)
          5'd16, 5'd17: begin
            pend_d  = mul_fn(A, B, (op == 5'd16));
            state_d = RUN;
            cnt_d   = CW'(MUL_CYCLES - 1);
          end
          5'd18, 5'd19: begin
            pend_d  = div_fn(A, B, (op == 5'd18));
            state_d = RUN;
            cnt_d   = CW'(DIV_CYCLES - 1);
          end
          5'd22:   hi_d = A;
          5'd23:   lo_d = A;
          default: ;
        endcase
      end
    end else begin
      if (cnt_q == '0) begin
        state_d = IDLE;
        hi_d    = pend_q[2*WIDTH-1:WIDTH];
        lo_d    = pend_q[WIDTH-1:0];
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_ff @(posedge clk) begin
    pend_q <= pend_d;
  end

endmodule

// File: doc/alu_mdu.md
ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, data path width (even, >= 8).
REQ-002 SHALL provide parameter MUL_CYCLES, default 5, busy cycles per multiply (>= 1).
REQ-003 SHALL provide parameter DIV_CYCLES, default 10, busy cycles per divide (>= 1).
REQ-004 SHALL define local SW = clog2(WIDTH), the shift-amount width.
REQ-005 SHALL have port clk, input, 1, single clock; all state updates on the rising edge.
REQ-006 SHALL have port reset_n, input, 1, synchronous active-low reset.
REQ-007 SHALL have port A, input, WIDTH, operand A (unsigned or two's complement, per op).
REQ-008 SHALL have port B, input, WIDTH, operand B.
REQ-009 SHALL have port s, input, SW, immediate shift amount.
REQ-010 SHALL have port op, input, 5, operation select.
REQ-011 SHALL have port start, input, 1, qualifies ops 16-19, 22 and 23 for one cycle.
REQ-012 SHALL have port result, output, WIDTH, combinational result.
REQ-013 SHALL have port busy, output, 1, registered; high while a multiply or divide is in flight.
REQ-014 SHALL have ports hi and lo, output, WIDTH each, registered HI/LO contents.

Function
REQ-015 SHALL compute combinationally on result: 0 A+B; 1 A-B; 2 and 7 A|B; 3 B<<A[SW-1:0]; 4 B>>>A[SW-1:0] (arithmetic); 5 B>>A[SW-1:0]; 6 A&B; 8 A^B; 9 ~(A|B); 10 signed A<B ? 1 : 0; 11 unsigned A<B ? 1 : 0; 12 B>>>s; 13 B>>s; 14 B<<s; 15 B<<(WIDTH/2).
REQ-016 SHALL drive result = hi for op 20 (MFHI), result = lo for op 21 (MFLO), and 0 for ops 16-19, 22, 23 and 24-31; result has no latches and ignores busy.
REQ-017 SHALL wrap add/sub modulo 2^WIDTH, with no overflow flag.
REQ-018 SHALL accept op 16 MULT (signed), 17 MULTU, 18 DIV (signed), 19 DIVU only on an edge where start=1 and busy=0; operands are captured on that edge.
REQ-019 SHALL ignore start=1 with ops 16-19/22/23 while busy=1: no state change, no queuing.
REQ-020 SHALL use states IDLE (busy=0) and RUN (busy=1) with a down-counter: accept -> RUN, counter = N-1 (N = MUL_CYCLES or DIV_CYCLES); each RUN edge decrements; edge at counter 0 -> IDLE.
REQ-021 SHALL keep busy high for exactly N cycles after the accepting edge; on the edge leaving RUN, write {hi,lo} and clear busy together.
REQ-022 SHALL form multiply as the full 2*WIDTH product of the captured operands: hi = upper half, lo = lower half.
REQ-023 SHALL set lo = quotient and hi = remainder for divide; signed quotient truncates toward zero, and the remainder takes the sign of the dividend.
REQ-024 SHALL give divide by zero lo = all ones and hi = dividend (signed and unsigned).
REQ-025 SHALL give signed overflow (most-negative / -1) lo = most-negative and hi = 0.
REQ-026 SHALL hold hi/lo at their old values throughout RUN, and changes on A/B/op during RUN SHALL not affect the in-flight result.
REQ-027 SHALL write hi = A on an edge with op 22 (MTHI), start=1, busy=0, and write lo = A with op 23 (MTLO); both are ignored while busy.
REQ-028 SHALL leave state unchanged on edges with start=0, or with start=1 and an op outside 16-19/22/23.

Reset
REQ-029 SHALL, on any edge with reset_n=0, set hi=0, lo=0, busy=0 and counter=0, enter IDLE, and take precedence over start.
REQ-030 SHALL have reset abort any in-flight operation: no hi/lo write occurs, and the first accept is possible on the first edge with reset_n=1.

Verification
REQ-031 WIDTH=32: A=0xFFFFFFFF, B=2, op=0 -> result 0x00000001; op=10 -> 1; op=11 -> 0; B=0x80000000, s=4, op=12 -> 0xF8000000.
REQ-032 MULT, A=0xFFFFFFFE (-2), B=3, start one cycle -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA; op=21 -> result 0xFFFFFFFA.
REQ-033 DIV A=-7, B=2 -> after 10 busy cycles lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU A=7, B=0 -> lo=0xFFFFFFFF, hi=7.
REQ-034 MULTU accepted, then MTHI A=0x1234 with start on busy cycle 2 -> ignored; final hi/lo = product; MTHI after busy drops -> hi=0x1234.
REQ-035 DIV accepted, reset_n=0 on busy cycle 3 -> next edge busy=0, hi=lo=0; no later hi/lo write; a new MULT accepted on the first edge after release.
REQ-036 WIDTH=16, MUL_CYCLES=1: MULTU 0xFFFF*0xFFFF -> busy one cycle, hi=0xFFFE, lo=0x0001; op=15, B=0x00AB -> result 0xAB00.
